// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer: opcode-aware multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller owning the PC
module mips_cycle_sequencer #(
  parameter int ADDR_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [5:0]        opcode,
  input  logic [5:0]        func,
  input  logic [15:0]       imm,
  input  logic              alu_zero,
  input  logic              mem_ready,
  output logic [2:0]        enable,
  output logic [ADDR_W-1:0] pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic              alu_start,
  output logic [5:0]        alu_func,
  output logic              reg_write,
  output logic [CNT_W-1:0]  instr_count,
  output logic              illegal
);
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B,
                         OP_BEQ = 6'h04, OP_J = 6'h02, OP_HALT = 6'h3F;
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
    MEMORY = 3'd4, WRITEBACK = 3'd5, HALT = 3'd7
  } state_t;
  state_t state, nxt;
  logic [5:0] op_q, alu_n;
  logic [ADDR_W-1:0] imm_q, pc_n;
  logic ill_n, sup, unused_imm;
  assign unused_imm = ^imm[15:ADDR_W];
  assign enable = state;
  assign sup = opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT};
  always_comb begin
    nxt = state;
    pc_n = pc;
    alu_n = alu_func;
    ill_n = illegal;
    case (state)
      IDLE: nxt = run ? FETCH : IDLE;
      FETCH: begin
        nxt = mem_ready ? DECODE : FETCH;
        pc_n = mem_ready ? pc + ADDR_W'(1) : pc;
      end
      DECODE: begin
        nxt = (!sup || opcode == OP_HALT) ? HALT : EXECUTE;
        ill_n = illegal | !sup;
        alu_n = opcode == OP_R ? func :
                opcode == OP_BEQ ? 6'h22 :
                opcode inside {OP_ADDI, OP_LW, OP_SW} ? 6'h20 : alu_func;
      end
      EXECUTE: begin
        nxt = op_q inside {OP_R, OP_ADDI} ? WRITEBACK :
              op_q inside {OP_LW, OP_SW} ? MEMORY : FETCH;
        pc_n = op_q == OP_J ? imm_q : (op_q == OP_BEQ && alu_zero) ? pc + imm_q : pc;
      end
      MEMORY: nxt = !mem_ready ? MEMORY : op_q == OP_LW ? WRITEBACK : FETCH;
      WRITEBACK: nxt = FETCH;
      default: nxt = HALT;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      alu_start <= 1'b0;
      alu_func <= '0;
      reg_write <= 1'b0;
      instr_count <= '0;
      illegal <= 1'b0;
      op_q <= '0;
      imm_q <= '0;
    end else begin
      state <= nxt;
      pc <= pc_n;
      alu_func <= alu_n;
      illegal <= ill_n;
      mem_req <= nxt == FETCH || nxt == MEMORY;
      mem_we <= nxt == MEMORY && op_q == OP_SW;
      alu_start <= nxt == EXECUTE;
      reg_write <= nxt == WRITEBACK;
      if (state == DECODE) begin
        op_q <= opcode;
        imm_q <= imm[ADDR_W-1:0];
      end
      // waiting in FETCH and the IDLE start do not count as retirement
      if (nxt == FETCH && state inside {EXECUTE, MEMORY, WRITEBACK})
        instr_count <= instr_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// tb_mips_cycle_sequencer: directed table plus random instruction stream against an instruction-level model
module tb_mips_cycle_sequencer;
  localparam int AW = 5, CW = 16;
  logic clock = 0, reset = 1, run = 0, alu_zero = 0, mem_ready = 0;
  logic [5:0] opcode = 0, func = 0;
  logic [15:0] imm = 0;
  logic [2:0] enable;
  logic [AW-1:0] pc;
  logic mem_req, mem_we, alu_start, reg_write, illegal;
  logic [5:0] alu_func;
  logic [CW-1:0] instr_count;

  mips_cycle_sequencer #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .func(func), .imm(imm),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .enable(enable), .pc(pc), .mem_req(mem_req),
    .mem_we(mem_we), .alu_start(alu_start), .alu_func(alu_func), .reg_write(reg_write),
    .instr_count(instr_count), .illegal(illegal));

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;
  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_cnt;
  logic [5:0] m_alu;
  logic m_ill;

  typedef struct {
    logic [5:0] op, f;
    logic [15:0] imm;
    logic z;
    int fw, mw;
    logic [AW-1:0] pc;
    logic [5:0] alu;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit sup(input logic [5:0] o);
    return o inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
  endfunction

  task automatic assert_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
    run = 0;
    chk("rst_enable", enable, 0);
    chk("rst_pc", pc, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_func", alu_func, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_illegal", illegal, 0);
    m_pc = 0; m_cnt = 0; m_alu = 0; m_ill = 0;
  endtask

  task automatic start();
    run = 1;
    @(negedge clock);
    run = 0;
  endtask

  // Called at a falling edge with the DUT in FETCH; returns at the falling edge after the instruction.
  task automatic do_instr(input logic [5:0] op, input logic [5:0] f, input logic [15:0] im,
                          input logic z, input int fw, input int mw);
    int q[$];
    bit halts;
    halts = !sup(op) || op == 6'h3F;
    for (int i = 0; i <= fw; i++) q.push_back(1);
    q.push_back(2);
    if (!halts) begin
      q.push_back(3);
      if (op == 6'h23 || op == 6'h2B) for (int i = 0; i <= mw; i++) q.push_back(4);
      if (op inside {6'h00, 6'h08, 6'h23}) q.push_back(5);
    end
    for (int i = 0; i < q.size(); i++) begin
      chk("enable", enable, q[i]);
      chk("mem_req", mem_req, q[i] == 1 || q[i] == 4);
      chk("mem_we", mem_we, q[i] == 4 && op == 6'h2B);
      chk("alu_start", alu_start, q[i] == 3);
      chk("reg_write", reg_write, q[i] == 5);
      mem_ready = (q[i] == 1 || q[i] == 4) ? (i + 1 == q.size() || q[i+1] != q[i]) : 1'($urandom);
      opcode = q[i] == 2 ? op : 6'($urandom);
      func = q[i] == 2 ? f : 6'($urandom);
      imm = q[i] == 2 ? im : 16'($urandom);
      alu_zero = q[i] == 3 ? z : 1'($urandom);
      run = 1'($urandom);
      @(negedge clock);
    end
    run = 0;
    m_pc = m_pc + 1'b1;
    if (op == 6'h04 && z) m_pc = m_pc + im[AW-1:0];
    if (op == 6'h02) m_pc = im[AW-1:0];
    if (op == 6'h00) m_alu = f;
    else if (op inside {6'h08, 6'h23, 6'h2B}) m_alu = 6'h20;
    else if (op == 6'h04) m_alu = 6'h22;
    if (!sup(op)) m_ill = 1;
    if (!halts) m_cnt = m_cnt + 1'b1;
    chk("end_enable", enable, halts ? 7 : 1);
    chk("pc", pc, m_pc);
    chk("instr_count", instr_count, m_cnt);
    chk("alu_func", alu_func, m_alu);
    chk("illegal", illegal, m_ill);
  endtask

  initial begin
    logic [5:0] ops[6];
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    tbl[0]  = '{6'h00, 6'h20, 16'h0000, 1'b0, 0, 0, 5'd1,  6'h20};
    tbl[1]  = '{6'h23, 6'h00, 16'h0000, 1'b0, 0, 3, 5'd2,  6'h20};
    tbl[2]  = '{6'h2B, 6'h11, 16'h0000, 1'b0, 2, 1, 5'd3,  6'h20};
    tbl[3]  = '{6'h08, 6'h00, 16'h0005, 1'b0, 0, 0, 5'd4,  6'h20};
    tbl[4]  = '{6'h04, 6'h00, 16'h0003, 1'b1, 0, 0, 5'd8,  6'h22};
    tbl[5]  = '{6'h02, 6'h3A, 16'h0004, 1'b1, 1, 0, 5'd4,  6'h22};
    tbl[6]  = '{6'h04, 6'h00, 16'h0003, 1'b0, 0, 0, 5'd5,  6'h22};
    tbl[7]  = '{6'h00, 6'h22, 16'h0000, 1'b0, 0, 0, 5'd6,  6'h22};
    tbl[8]  = '{6'h02, 6'h00, 16'h001E, 1'b0, 0, 0, 5'd30, 6'h22};
    tbl[9]  = '{6'h02, 6'h00, 16'h001F, 1'b0, 0, 0, 5'd31, 6'h22};
    tbl[10] = '{6'h00, 6'h24, 16'h0000, 1'b0, 0, 0, 5'd0,  6'h24};
    tbl[11] = '{6'h04, 6'h00, 16'hFFFF, 1'b1, 0, 0, 5'd0,  6'h22};
    @(negedge clock);
    assert_reset();
    start();
    for (int i = 0; i < 12; i++) begin
      do_instr(tbl[i].op, tbl[i].f, tbl[i].imm, tbl[i].z, tbl[i].fw, tbl[i].mw);
      chk("tbl_pc", pc, tbl[i].pc);
      chk("tbl_alu_func", alu_func, tbl[i].alu);
    end
    chk("tbl_count", instr_count, 12);
    for (int i = 0; i < 60; i++)
      do_instr(ops[$urandom_range(0, 5)], 6'($urandom), 16'($urandom), 1'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 3));
    // reset in the middle of a stalled lw memory access
    opcode = 6'h23;
    mem_ready = 1;
    @(negedge clock);
    chk("mr_decode", enable, 2);
    @(negedge clock);
    chk("mr_execute", enable, 3);
    mem_ready = 0;
    @(negedge clock);
    chk("mr_memory", enable, 4);
    chk("mr_mem_req", mem_req, 1);
    chk("mr_mem_we", mem_we, 0);
    @(negedge clock);
    chk("mr_memory_wait", enable, 4);
    assert_reset();
    start();
    do_instr(6'h00, 6'h25, 16'h0000, 1'b0, 0, 0);
    chk("restart_pc", pc, 1);
    do_instr(6'h3F, 6'h00, 16'h0000, 1'b0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      run = 1'(i % 2 == 0);
      mem_ready = 1;
      @(negedge clock);
      chk("halt_enable", enable, 7);
      chk("halt_pc", pc, m_pc);
      chk("halt_count", instr_count, m_cnt);
      chk("halt_mem_req", mem_req, 0);
      chk("halt_alu_start", alu_start, 0);
    end
    run = 0;
    assert_reset();
    start();
    do_instr(6'h11, 6'h00, 16'h0000, 1'b0, 0, 0);
    chk("illegal_set", illegal, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_cycle_sequencer.md
Name: mips_cycle_sequencer

Overview:
Multi-cycle control sequencer for the MIPS datapath (program memory, instruction split, register file, ALU). It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and owns the program counter. It drives the shared 3-bit stage enable bus and the per-stage strobes, and handshakes with a memory port that may insert wait states. It replaces the free-running stage FSM with one that is opcode-aware.

Parameters:
ADDR_W, 5, program counter / instruction address width (word addressed)
CNT_W, 16, width of the retired-instruction counter

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
run  in  1  single-cycle start pulse; sampled only in IDLE
opcode  in  6  instruction opcode from the split block; valid during DECODE
func  in  6  R-type function field; valid during DECODE
imm  in  16  immediate / jump target low bits; valid during DECODE
alu_zero  in  1  ALU zero flag; valid during EXECUTE
mem_ready  in  1  memory handshake acknowledge
enable  out  3  stage code: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK, 7 HALT
pc  out  ADDR_W  current instruction address
mem_req  out  1  memory request; high in FETCH, and in MEMORY for lw/sw
mem_we  out  1  memory write; high with mem_req in MEMORY for sw only
alu_start  out  1  one-cycle strobe on entry to EXECUTE
alu_func  out  6  latched func for R-type; 6'h20 (add) for addi/lw/sw; 6'h22 (sub) for beq
reg_write  out  1  high during WRITEBACK for R-type, addi and lw
instr_count  out  CNT_W  number of retired instructions
illegal  out  1  sticky; set when an unsupported opcode is decoded

Behaviour:
- All outputs are registered (Moore). On reset: enable=0, pc=0, mem_req=0, mem_we=0, alu_start=0, alu_func=0, reg_write=0, instr_count=0, illegal=0, state=IDLE. Reset has priority over everything, in any state, including mid-handshake.
- IDLE: wait for run=1, then go to FETCH. run is ignored in all other states.
- FETCH: mem_req=1. Stay while mem_ready=0. When mem_ready=1 is sampled: pc <= pc+1 (modulo 2^ADDR_W), go to DECODE. mem_ready is ignored whenever mem_req=0.
- DECODE (exactly 1 cycle): latch opcode, func and imm.
  - Supported opcodes: R 6'h00, addi 6'h08, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02, halt 6'h3F.
  - halt goes to HALT.
  - Any unsupported opcode sets illegal=1 and goes to HALT.
  - All other supported opcodes go to EXECUTE.
- EXECUTE (exactly 1 cycle): alu_start=1 for this cycle only.
  - R-type and addi go to WRITEBACK.
  - lw and sw go to MEMORY.
  - beq: if alu_zero=1, pc <= pc + imm[ADDR_W-1:0], where pc is already incremented and the sum wraps. Then retire to FETCH.
  - j: pc <= imm[ADDR_W-1:0], then retire to FETCH.
- MEMORY: mem_req=1; mem_we=1 for sw only. Stay while mem_ready=0.
  - On mem_ready=1: lw goes to WRITEBACK; sw retires to FETCH.
- WRITEBACK (exactly 1 cycle): reg_write=1, then retire to FETCH.
- Retire means instr_count <= instr_count+1 (wraps at 2^CNT_W) on the transition into FETCH. halt and illegal instructions do not retire.
- HALT: enable=7, all strobes 0, pc and instr_count frozen. Only reset leaves HALT.
- Zero-wait latencies, FETCH entry to next FETCH entry:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
  - Each wait cycle adds 1.
- enable reflects the current state every cycle. A held mem_ready=1 does not skip any stage.

Test Plan:
- Reset then run with opcode=0x00, func=0x20, mem_ready=1 -> enable sequence 1,2,3,5,1; reg_write high 1 cycle; alu_func=0x20; pc=1; instr_count=1 at the second FETCH.
- lw (0x23) with mem_ready low for 3 cycles in MEMORY -> MEMORY lasts 4 cycles with mem_req=1, mem_we=0; then WRITEBACK; total 8 cycles.
- beq at pc=4 with imm=3, alu_zero=1 -> next pc=8. Same with alu_zero=0 -> pc=5. sw -> mem_we=1 in MEMORY, no reg_write.
- j with imm=0x001F at pc=31 -> pc=31; then pc+1 wraps to 0 in the following FETCH.
- opcode 0x3F -> enable=7, illegal=0, instr_count unchanged. opcode 0x11 -> HALT with illegal=1. run pulses in HALT -> no change.
- Assert reset during MEMORY wait, while mem_req=1 -> next cycle all outputs at reset values, state IDLE. Run restarts at pc=0.
